if_fetch_queue: RTL and testbench



---
 rtl/if_fetch_queue.sv | 102 ++++++++++
 tb/tb_if_fetch_queue.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: first-word-fall-through prefetch FIFO between fetch and the IF/ID register.
// Define FETCH_QUEUE_STATS_EN to add the max_count / flush_drops statistics outputs.
module if_fetch_queue #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_instr,
    output logic          in_ready,
    output logic          out_valid,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_instr,
    input  logic          out_ready,
    output logic [AW:0]   count
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [AW:0]   max_count,
    output logic [15:0]   flush_drops
`endif
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_count_next;
    logic [63:0]   w_head;

    assign in_ready  = (r_count != FULL_CNT);
    assign out_valid = (r_count != '0);
    assign count     = r_count;

    assign w_push = in_valid & in_ready & ~flush;
    assign w_pop  = out_valid & out_ready & ~flush;

    // Empty head reads as zero so the IF/ID register latches a bubble.
    assign w_head    = out_valid ? r_mem[r_rd_ptr] : 64'd0;
    assign out_pc    = w_head[63:32];
    assign out_instr = w_head[31:0];

    always_comb begin
        w_count_next = r_count;
        if (flush) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + (AW+1)'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_next;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {in_pc, in_instr};
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic [AW:0] r_max_count;
    logic [15:0] r_flush_drops;
    logic [16:0] w_drops_sum;

    assign w_drops_sum = {1'b0, r_flush_drops} + 17'(r_count);
    assign max_count   = r_max_count;
    assign flush_drops = r_flush_drops;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_max_count   <= '0;
            r_flush_drops <= '0;
        end else begin
            if (w_count_next > r_max_count) r_max_count <= w_count_next;
            if (flush) r_flush_drops <= w_drops_sum[16] ? 16'hFFFF : w_drops_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: a queue of expected {pc, instr} entries is compared
// against the FWFT head every cycle; the reference occupancy is the scoreboard size.
module tb_if_fetch_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [31:0]   in_pc;
    logic [31:0]   in_instr;
    logic          in_ready;
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic          out_ready;
    logic [AW:0]   count;
`ifdef FETCH_QUEUE_STATS_EN
    logic [AW:0]   max_count;
    logic [15:0]   flush_drops;
`endif

    always #5 clk = ~clk;

    if_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
`ifdef FETCH_QUEUE_STATS_EN
        ,
        .max_count   (max_count),
        .flush_drops (flush_drops)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];
    int          m_max   = 0;
    int          m_drops = 0;
    bit          m_known = 1'b0;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check the current registered state, then advance the model.
    task automatic step(input bit r, input bit iv, input logic [31:0] pc, input bit ordy, input bit fl);
        logic [63:0] head;
        int          cnt;
        bit          push;
        bit          pop;
        rst       = r;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = instr_of(pc);
        out_ready = ordy;
        flush     = fl;
        #1;
        cnt = sb.size();
        if (m_known) begin
            head = (cnt != 0) ? sb[0] : 64'd0;
            chk("count",     64'(count),     64'(cnt));
            chk("in_ready",  64'(in_ready),  64'(cnt != DEPTH));
            chk("out_valid", 64'(out_valid), 64'(cnt != 0));
            chk("out_head",  {out_pc, out_instr}, head);
`ifdef FETCH_QUEUE_STATS_EN
            chk("max_count",   64'(max_count),   64'(m_max));
            chk("flush_drops", 64'(flush_drops), 64'(m_drops));
`endif
        end
        push = iv && (cnt != DEPTH) && !fl;
        pop  = (cnt != 0) && ordy && !fl;
        @(posedge clk);
        if (r) begin
            sb.delete();
            m_max   = 0;
            m_drops = 0;
            m_known = 1'b1;
        end else if (fl) begin
            m_drops = (m_drops + cnt > 65535) ? 65535 : m_drops + cnt;
            sb.delete();
        end else begin
            if (pop)  void'(sb.pop_front());
            if (push) sb.push_back({pc, instr_of(pc)});
            if (sb.size() > m_max) m_max = sb.size();
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;

        // Reset then idle
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);

        // Fill to 3, then reset for 2 cycles while still offering (and flushing on one cycle)
        step(0, 1, 32'h4,  0, 0);
        step(0, 1, 32'h8,  0, 0);
        step(0, 1, 32'hC,  0, 0);
        step(1, 1, 32'h10, 1, 1);
        step(1, 1, 32'h14, 0, 0);
        step(0, 0, 0, 0, 0);

        // Push 4,8,12 stalled, then drain in order
        step(0, 1, 32'h4, 0, 0);
        step(0, 1, 32'h8, 0, 0);
        step(0, 1, 32'hC, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);

        // Fill to DEPTH, offer pc 20 while full, pop one, pc 20 accepted next and exits last
        for (int i = 0; i < DEPTH; i++) step(0, 1, 32'h100 + 32'(4*i), 0, 0);
        step(0, 1, 32'h20, 0, 0);
        step(0, 1, 32'h20, 0, 0);
        step(0, 1, 32'h20, 1, 0);
        step(0, 1, 32'h20, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 1, 0);

        // Streaming with simultaneous push/pop, pointers wrap several times
        for (int i = 0; i < 20; i++) step(0, 1, 32'h1000 + 32'(4*i), 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        // Flush at count=3 with push and pop offered; new entry then reaches the head
        step(0, 1, 32'h200, 0, 0);
        step(0, 1, 32'h204, 0, 0);
        step(0, 1, 32'h208, 0, 0);
        step(0, 1, 32'h40,  1, 1);
        step(0, 1, 32'h80,  0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // Statistics scenario: fill, pop one, flush three
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 32'h300 + 32'(4*i), 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 1, 32'h400, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
